// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  // Reserved size or a natural-alignment violation for the requested width.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract for loads and lane merge for stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_in[7:0];
    case (addr_lo)
      2'b00:   w_byte = word_in[7:0];
      2'b01:   w_byte = word_in[15:8];
      2'b10:   w_byte = word_in[23:16];
      default: w_byte = word_in[31:24];
    endcase
    w_half = addr_lo[1] ? word_in[31:16] : word_in[15:0];
  end

  always_comb begin
    load_data = word_in;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: load_data = {{16{sign_ext & w_half[15]}}, w_half};
      default: load_data = word_in;
    endcase
  end

  // Untouched lanes keep the word captured during the read phase.
  always_comb begin
    merge_data = word_in;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'b00:   merge_data = {word_in[31:8], store_data[7:0]};
          2'b01:   merge_data = {word_in[31:16], store_data[7:0], word_in[7:0]};
          2'b10:   merge_data = {word_in[31:24], store_data[7:0], word_in[15:0]};
          default: merge_data = {store_data[7:0], word_in[23:0]};
        endcase
      end
      SZ_HALF: merge_data = addr_lo[1] ? {store_data[15:0], word_in[15:0]}
                                       : {word_in[31:16], store_data[15:0]};
      default: merge_data = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  r_state;
  logic        r_we;
  logic        r_sign_ext;
  logic        r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;

  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_err = access_err(size, addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_sign_ext <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_word     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we       <= we;
            r_sign_ext <= sign_ext;
            r_err      <= w_err;
            r_size     <= size;
            r_addr     <= addr;
            r_wdata    <= wdata;
            if (w_err)                r_state <= ST_RESP;
            else if (!we)             r_state <= ST_RD;
            else if (size == SZ_WORD) r_state <= ST_WR;
            else                      r_state <= ST_RMW_RD;
          end
        end
        ST_RD: begin
          r_word  <= mem_rd;
          r_state <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_word  <= mem_rd;
          r_state <= ST_WR;
        end
        ST_WR:   r_state <= ST_RESP;
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lsu_lane_align u_lane_align (
    .size       (r_size),
    .sign_ext   (r_sign_ext),
    .addr_lo    (r_addr[1:0]),
    .word_in    (r_word),
    .store_data (r_wdata),
    .load_data  (w_load),
    .merge_data (w_merge)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_RESP);
  assign err      = done & r_err;
  assign rdata    = (done && !r_err && !r_we) ? w_load : 32'd0;
  assign MemRead  = (r_state == ST_RD) || (r_state == ST_RMW_RD);
  // Gating with rst lets a reset landing in WR abort the write on that same edge.
  assign MemWrite = (r_state == ST_WR) && !rst;
  assign mem_addr = busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wd   = (r_state == ST_WR) ? w_merge : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];

  int n_checks;
  int n_fail;

  load_store_unit dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[7:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One request from IDLE; returns cycles to done, result, and memory strobe counts.
  task automatic lsu_access(input logic a_we, input logic [1:0] a_size, input logic a_sx,
                            input logic [31:0] a_addr, input logic [31:0] a_wdata,
                            output int lat, output logic [31:0] got_rdata, output logic got_err,
                            output int n_rd, output int n_wr);
    @(negedge clk);
    req = 1'b1; we = a_we; size = a_size; sign_ext = a_sx; addr = a_addr; wdata = a_wdata;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0; got_rdata = 32'd0; got_err = 1'b0; n_rd = 0; n_wr = 0;
    for (int i = 1; i <= 8; i++) begin
      if (MemRead)  n_rd++;
      if (MemWrite) n_wr++;
      if (done) begin
        lat = i; got_rdata = rdata; got_err = err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          nr;
  int          nw;
  int          b_done;
  int          b_rd;
  int          b_idle;
  int          b_overlap;
  int          b_bad;
  logic        prev_done;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then word load
    lsu_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nr, nw);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_nwr", 32'(nw), 32'd1);
    check("sw_nrd", 32'(nr), 32'd0);
    check("sw_byte10", 32'(mem[4][7:0]), 32'hEF);
    check("sw_byte11", 32'(mem[4][15:8]), 32'hBE);
    check("sw_byte12", 32'(mem[4][23:16]), 32'hAD);
    check("sw_byte13", 32'(mem[4][31:24]), 32'hDE);
    lsu_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nr, nw);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_nrd", 32'(nr), 32'd1);

    // Byte store read-modify-write
    lsu_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er, nr, nw);
    lsu_access(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, lat, rd, er, nr, nw);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_nrd", 32'(nr), 32'd1);
    check("sb_nwr", 32'(nw), 32'd1);
    check("sb_mem", mem[8], 32'h11AA3344);
    lsu_access(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF, lat, rd, er, nr, nw);
    check("sh_mem", mem[8], 32'h11AABEEF);
    lsu_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, nr, nw);
    check("sh_readback", rd, 32'h11AABEEF);

    // Sign / zero extension
    lsu_access(1'b1, 2'b10, 1'b0, 32'h30, 32'h0080FF7F, lat, rd, er, nr, nw);
    lsu_access(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, lat, rd, er, nr, nw);
    check("lb31_sx", rd, 32'hFFFFFFFF);
    lsu_access(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, lat, rd, er, nr, nw);
    check("lb30_sx", rd, 32'h0000007F);
    lsu_access(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, rd, er, nr, nw);
    check("lh32_zx", rd, 32'h00000080);
    lsu_access(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, lat, rd, er, nr, nw);
    check("lh30_sx", rd, 32'hFFFFFF7F);
    lsu_access(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, lat, rd, er, nr, nw);
    check("lb31_zx", rd, 32'h000000FF);

    // Error cases
    lsu_access(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, lat, rd, er, nr, nw);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_nrd", 32'(nr), 32'd0);
    check("mis_nwr", 32'(nw), 32'd0);
    lsu_access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, lat, rd, er, nr, nw);
    check("rsvd_err", 32'(er), 32'd1);
    lsu_access(1'b1, 2'b01, 1'b0, 32'h21, 32'h00005555, lat, rd, er, nr, nw);
    check("mis_sh_err", 32'(er), 32'd1);
    check("mis_sh_nwr", 32'(nw), 32'd0);
    check("mis_sh_mem", mem[8], 32'h11AABEEF);

    // Reset during WR
    lsu_access(1'b1, 2'b10, 1'b0, 32'h50, 32'h12345678, lat, rd, er, nr, nw);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h50; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h50);
    check("wr_memwrite", 32'(MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check("wr_rst_gate", 32'(MemWrite), 32'd0);
    @(posedge clk); #1;
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_mem", mem[20], 32'h12345678);
    rst = 1'b0;
    lsu_access(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, lat, rd, er, nr, nw);
    check("rstwr_load_lat", 32'(lat), 32'd2);
    check("rstwr_load", rd, 32'h12345678);

    // Back-to-back requests with req held high
    b_done = 0; b_rd = 0; b_idle = 0; b_overlap = 0; b_bad = 0; prev_done = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done) begin
        b_done++;
        if (prev_done) b_overlap++;
        if (rdata !== 32'hDEADBEEF) b_bad++;
      end
      if (MemRead) b_rd++;
      if (!busy) b_idle++;
      prev_done = done;
    end
    req = 1'b0;
    @(posedge clk); #1;
    check("b2b_done", 32'(b_done), 32'd4);
    check("b2b_reads", 32'(b_rd), 32'd4);
    check("b2b_idle", 32'(b_idle), 32'd4);
    check("b2b_overlap", 32'(b_overlap), 32'd0);
    check("b2b_rdata", 32'(b_bad), 32'd0);
    check("b2b_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have the following ports.
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load result, valid while done=1.
- err  out  1  valid with done; misaligned or reserved size.
- MemRead  out  1  to data memory read enable.
- MemWrite  out  1  to data memory write enable; memory writes on posedge.
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}.
- mem_wd  out  32  write word, little-endian byte lanes.
- mem_rd  in  32  combinational read word from memory.

Function
REQ-002 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP.
REQ-003 In IDLE with req=1, SHALL latch we, size, sign_ext, addr and wdata, then transition.
- Load -> RD.
- Word store -> WR.
- Byte/half store -> RMW_RD.
- Error -> RESP.
REQ-004 SHALL flag error for size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00. Error SHALL cause no memory access.
REQ-005 In RD and RMW_RD, SHALL hold MemRead=1 and capture mem_rd into an internal word register on the exiting posedge. MemRead SHALL be 0 in all other states.
REQ-006 In WR, SHALL hold MemWrite=1 for exactly one cycle. MemWrite SHALL be 0 in all other states and whenever rst=1.
REQ-007 RD SHALL go to RESP; RMW_RD SHALL go to WR; WR SHALL go to RESP; RESP SHALL go to IDLE.
REQ-008 In RESP, SHALL assert done=1 for exactly one cycle with err valid.
REQ-009 Load result SHALL be the byte lane selected by addr[1:0], or the half lane selected by addr[1], extended per sign_ext. rdata SHALL be 0 when err=1 and outside RESP.
REQ-010 Sub-word store SHALL replace only the addressed lane(s) of the captured word with wdata[7:0] or wdata[15:0]; other lanes SHALL be unchanged.
REQ-011 mem_wd SHALL be 0 outside WR. mem_addr SHALL hold the latched aligned address while busy and be 0 in IDLE.
REQ-012 Latency from req acceptance edge to done: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-013 req while busy SHALL be ignored; it is not queued. req in the RESP cycle SHALL also be ignored; earliest next accept is the IDLE cycle after RESP.

Reset
REQ-014 On rst=1 at posedge, SHALL enter IDLE and clear the latched request and captured word. Outputs SHALL be busy=0, done=0, err=0, rdata=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wd=0.
REQ-015 Reset mid-operation SHALL abort without any memory write, including when asserted during the WR cycle, because MemWrite is gated by rst.

Structure
REQ-016 Size encodings and the state enumeration SHALL reside in shared package lsu_pkg.
REQ-017 Lane extract and merge logic SHALL be one combinational sub-module, lsu_lane_align; the FSM stays in load_store_unit.

Verification
REQ-018 Word store then load: store 0xDEADBEEF at addr 0x10, then load word at 0x10 -> memory bytes 0x10..0x13 = EF,BE,AD,DE; done at +2 cycles; rdata=0xDEADBEEF, err=0.
REQ-019 Byte store RMW: word 0x11223344 at 0x20, store byte 0xAA at 0x22 -> one MemRead cycle then one MemWrite cycle; word reads back 0x11AA3344; done at +3 cycles.
REQ-020 Sign extension: word 0x0080FF7F at 0x30; byte load 0x31 with sign_ext=1 -> 0xFFFFFFFF; byte load 0x30 with sign_ext=1 -> 0x0000007F; half load 0x32 with sign_ext=0 -> 0x00000080.
REQ-021 Misaligned: word load at 0x41 -> done at +1 cycle with err=1, rdata=0; MemRead and MemWrite never asserted.
REQ-022 Reset in WR: rst=1 during a store's WR cycle -> memory unchanged, next-cycle busy=0, and a following load accepted normally.
REQ-023 Back-to-back: req held high continuously -> accepts only in IDLE; done pulses never overlap and no request is lost or duplicated per acceptance.
